// File: rtl/msg_serializer.sv
// msg_serializer: framed serial transmitter for a 5-bit message.
// Frame on the line: start bit (0), 5 data bits LSB first, optional even
// parity bit, stop bit (1). Bit boundaries come from rising edges of the
// divided clock tick_in.
// Optional feature macro: MSG_PARITY_EN (adds the parity bit to the frame).
module msg_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start,
  input  logic [4:0] msg,
  output logic       ser_out,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC   = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
`ifdef MSG_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif
  localparam logic [2:0] ST_STOP   = 3'd5;

  logic [2:0] state_reg, state_next;
  logic       tick_d_reg;
  logic [4:0] shreg_reg, shreg_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       ser_reg, ser_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
`ifdef MSG_PARITY_EN
  logic       par_reg, par_next;
`endif

  // Only the first cycle of a high tick_in level counts as a bit boundary.
  logic tick_rise;
  assign tick_rise = tick_in & ~tick_d_reg;

  // Next-state and next-output logic; outputs are computed one step ahead
  // so that every port is driven straight from a flop.
  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
    ser_next   = ser_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
`ifdef MSG_PARITY_EN
    par_next   = par_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        ser_next  = 1'b1;
        busy_next = 1'b0;
        if (start) begin
          shreg_next = msg;
          cnt_next   = 3'd0;
`ifdef MSG_PARITY_EN
          par_next   = ^msg;
`endif
          busy_next  = 1'b1;
          state_next = ST_SYNC;
        end
      end
      // Waits for a fresh tick so the start bit lasts a full bit period.
      ST_SYNC: begin
        if (tick_rise) begin
          ser_next   = 1'b0;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (tick_rise) begin
          ser_next   = shreg_reg[0];
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick_rise) begin
          if (cnt_reg == 3'd4) begin
`ifdef MSG_PARITY_EN
            ser_next   = par_reg;
            state_next = ST_PARITY;
`else
            ser_next   = 1'b1;
            state_next = ST_STOP;
`endif
          end else begin
            shreg_next = {1'b0, shreg_reg[4:1]};
            cnt_next   = cnt_reg + 3'd1;
            ser_next   = shreg_reg[1];
          end
        end
      end
`ifdef MSG_PARITY_EN
      ST_PARITY: begin
        if (tick_rise) begin
          ser_next   = 1'b1;
          state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick_rise) begin
          ser_next   = 1'b1;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        ser_next   = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      tick_d_reg <= 1'b0;
      shreg_reg  <= 5'd0;
      cnt_reg    <= 3'd0;
      ser_reg    <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
`ifdef MSG_PARITY_EN
      par_reg    <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      tick_d_reg <= tick_in;
      shreg_reg  <= shreg_next;
      cnt_reg    <= cnt_next;
      ser_reg    <= ser_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
`ifdef MSG_PARITY_EN
      par_reg    <= par_next;
`endif
    end
  end

  assign ser_out = ser_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: doc/msg_serializer.md
# msg_serializer

Frame-based serial transmitter that sits directly downstream of the divider/mux stage. The selected divided clock (fixed or loadable divider, chosen by the mux) enters as `tick_in` and sets the bit rate. On each request the block latches a 5-bit message and shifts it out as one framed serial word: start bit, 5 data bits LSB first, optional parity bit, stop bit. It lets the board transmit the `msg` switches at a rate chosen by `SW` and `sel`.

## Interface
- No parameters; the data width is fixed at 5 bits.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `tick_in`  input  1  divided-clock level from the upstream mux; its rising edges define bit boundaries.
- `start`  input  1  transmit request, level-sampled; honoured only in IDLE.
- `msg`  input  5  message; latched on the cycle `start` is accepted.
- `ser_out`  output  1  serial line; idles high.
- `busy`  output  1  high from the cycle after acceptance until frame end.
- `done`  output  1  one-cycle pulse at frame end.

## Operation
- Edge detect: `tick_d` is a registered copy of `tick_in` (reset 0). `tick_rise = tick_in & ~tick_d`. Only `tick_rise` advances the FSM; `tick_in` level is otherwise ignored.
- FSM states: IDLE, SYNC, START, DATA, PARITY (only if compiled in), STOP.
- IDLE: `ser_out`=1, `busy`=0. If `start`=1, latch `msg` into a 5-bit shift register, clear the 3-bit bit counter, and go to SYNC.
- SYNC: `ser_out`=1. On `tick_rise` go to START. This makes the start bit a full bit period.
- START: `ser_out`=0. On `tick_rise` go to DATA with `ser_out`=shreg[0].
- DATA: `ser_out`=shreg[0]. On each `tick_rise`, shift right and increment the counter. After bit 4 completes (count 4 on the `tick_rise`), go to PARITY if enabled, otherwise STOP.
- PARITY: `ser_out` = XOR of the latched message (even parity over data plus parity bit). On `tick_rise` go to STOP.
- STOP: `ser_out`=1. On `tick_rise` go to IDLE and pulse `done` for that one cycle.
- `start` while not IDLE is ignored; it is not queued.
- `msg` changes after acceptance do not affect the frame in flight.
- `start` held high continuously: a new frame is accepted on the first IDLE cycle after `done`, i.e. back-to-back frames.

## Timing
- All outputs are registered.
- Reset values: `ser_out`=1, `busy`=0, `done`=0, state IDLE, `tick_d`=0, shift register 0, counter 0.
- Acceptance: `start` sampled high in IDLE at edge N gives `busy`=1 from N+1. The FSM is in SYNC at N+1.
- `ser_out` changes on the clock edge that registers `tick_rise` (1 cycle after `tick_in` rises at the sample point).
- A `tick_rise` coinciding with the acceptance cycle is not consumed; SYNC waits for the next one.
- Frame length, counted in `tick_rise` events after acceptance:
  - 8 without parity: SYNC, START, 5 data bits, STOP.
  - 9 with parity.
- `done` rises on the same edge on which `busy` falls and the state returns to IDLE.
- Reset mid-frame: on the next edge all outputs take their reset values; no `done` pulse.
- `tick_in` stuck high or stuck low: the FSM holds its current state indefinitely and `ser_out` holds steady.

## Configuration
- `MSG_PARITY_EN` defined: the PARITY state exists, the frame is 8 bit periods on the line, and `done` follows the 9th `tick_rise`.
- `MSG_PARITY_EN` undefined: PARITY is removed, DATA goes directly to STOP, the frame is 7 bit periods on the line, and `done` follows the 8th `tick_rise`.

## Test plan
In every scenario, `tick_in` is high for 1 cycle every 4 cycles.

- Reset, then 10 idle cycles -> `ser_out`=1, `busy`=0, `done`=0 throughout.
- Pulse `start` with `msg`=5'b10110, no parity -> bit-period sequence on `ser_out` is 0,0,1,1,0,1,1. `done` pulses once, after the 8th `tick_rise`.
- Same stimulus with `MSG_PARITY_EN` -> sequence 0,0,1,1,0,1,1,1 (parity bit 1). `done` pulses after the 9th `tick_rise`.
- Pulse `start` with `msg`=5'b00001, then change `msg` to 5'b11111 and pulse `start` again mid-frame -> transmitted data is 1,0,0,0,0; the second `start` is ignored; exactly one `done`.
- Hold `start` high with `msg`=5'b00000 -> two back-to-back frames. `busy` is low for exactly one cycle between them, coinciding with `done`.
- Drive `rst`=0 during DATA bit 2 -> next edge `ser_out`=1, `busy`=0, no `done`. After `rst`=1 with `start` low, the line stays idle.
